morse_char_assembler: RTL and testbench



---
 rtl/morse_char_assembler_pkg.sv | 19 +
 rtl/morse_lut.sv | 63 ++++++
 rtl/morse_char_assembler.sv | 138 +++++++++++++
 tb/tb_morse_char_assembler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_char_assembler_pkg.sv
// -----------------------------------------------------------------------------
// morse_char_assembler_pkg
// Shared definitions for the Morse character assembler and its lookup table:
// ASCII constants, symbol field widths and the assembler state encoding.
// -----------------------------------------------------------------------------
package morse_char_assembler_pkg;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    localparam int MORSE_LEN_W = 3;
    localparam int MORSE_PAT_W = 5;

    typedef enum logic {
        COLLECT    = 1'b0,
        EMIT_SPACE = 1'b1
    } state_t;

endpackage

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Purely combinational map of a Morse symbol to ASCII. The pattern holds one
// bit per element (dot = 0, dash = 1) with the first element at bit len-1.
// Ports:
//   len     in   3  number of elements in the symbol
//   pattern in   5  element bits, right-aligned
//   ascii   out  8  A-Z / 0-9, or '?' for any unassigned code
// -----------------------------------------------------------------------------
module morse_lut
    import morse_char_assembler_pkg::*;
(
    input  logic [MORSE_LEN_W-1:0] len,
    input  logic [MORSE_PAT_W-1:0] pattern,
    output logic [7:0]             ascii
);

    always_comb begin
        // NOTE: ascii gets a default before the case so an unlisted code
        // cannot leave it unassigned and infer a latch.
        ascii = ASCII_UNKNOWN;
        case ({len, pattern})
            {3'd2, 5'b00001}: ascii = 8'h41; // A .-
            {3'd4, 5'b01000}: ascii = 8'h42; // B -...
            {3'd4, 5'b01010}: ascii = 8'h43; // C -.-.
            {3'd3, 5'b00100}: ascii = 8'h44; // D -..
            {3'd1, 5'b00000}: ascii = 8'h45; // E .
            {3'd4, 5'b00010}: ascii = 8'h46; // F ..-.
            {3'd3, 5'b00110}: ascii = 8'h47; // G --.
            {3'd4, 5'b00000}: ascii = 8'h48; // H ....
            {3'd2, 5'b00000}: ascii = 8'h49; // I ..
            {3'd4, 5'b00111}: ascii = 8'h4A; // J .---
            {3'd3, 5'b00101}: ascii = 8'h4B; // K -.-
            {3'd4, 5'b00100}: ascii = 8'h4C; // L .-..
            {3'd2, 5'b00011}: ascii = 8'h4D; // M --
            {3'd2, 5'b00010}: ascii = 8'h4E; // N -.
            {3'd3, 5'b00111}: ascii = 8'h4F; // O ---
            {3'd4, 5'b00110}: ascii = 8'h50; // P .--.
            {3'd4, 5'b01101}: ascii = 8'h51; // Q --.-
            {3'd3, 5'b00010}: ascii = 8'h52; // R .-.
            {3'd3, 5'b00000}: ascii = 8'h53; // S ...
            {3'd1, 5'b00001}: ascii = 8'h54; // T -
            {3'd3, 5'b00001}: ascii = 8'h55; // U ..-
            {3'd4, 5'b00001}: ascii = 8'h56; // V ...-
            {3'd3, 5'b00011}: ascii = 8'h57; // W .--
            {3'd4, 5'b01001}: ascii = 8'h58; // X -..-
            {3'd4, 5'b01011}: ascii = 8'h59; // Y -.--
            {3'd4, 5'b01100}: ascii = 8'h5A; // Z --..
            {3'd5, 5'b11111}: ascii = 8'h30; // 0 -----
            {3'd5, 5'b01111}: ascii = 8'h31; // 1 .----
            {3'd5, 5'b00111}: ascii = 8'h32; // 2 ..---
            {3'd5, 5'b00011}: ascii = 8'h33; // 3 ...--
            {3'd5, 5'b00001}: ascii = 8'h34; // 4 ....-
            {3'd5, 5'b00000}: ascii = 8'h35; // 5 .....
            {3'd5, 5'b10000}: ascii = 8'h36; // 6 -....
            {3'd5, 5'b11000}: ascii = 8'h37; // 7 --...
            {3'd5, 5'b11100}: ascii = 8'h38; // 8 ---..
            {3'd5, 5'b11110}: ascii = 8'h39; // 9 ----.
            default:          ascii = ASCII_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/morse_char_assembler.sv
// -----------------------------------------------------------------------------
// morse_char_assembler
// Collects dot/dash pulses into a symbol, closes it on a letter or word gap,
// translates it to ASCII and queues it in a small FIFO. A word gap also queues
// a space one cycle after the letter.
// Ports:
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   dot, dash  in   1  single-cycle element pulses
//   lg, wg     in   1  single-cycle letter-gap / word-gap pulses
//   char_data  out  8  ASCII at the FIFO head (0 while empty)
//   char_valid out  1  FIFO not empty
//   char_ready in   1  consumer pops when char_valid & char_ready
//   overflow   out  1  sticky: a character was dropped on a full FIFO
// -----------------------------------------------------------------------------
module morse_char_assembler
    import morse_char_assembler_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_ELEMENTS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot,
    input  logic       dash,
    input  logic       lg,
    input  logic       wg,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [MORSE_LEN_W-1:0] LEN_MAX    = MORSE_LEN_W'(MAX_ELEMENTS);
    localparam logic [AW:0]            FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    state_t                 state, state_next;
    logic [MORSE_LEN_W-1:0] len, len_next, base_len;
    logic [MORSE_PAT_W-1:0] pattern, pattern_next, base_pat;
    logic                   too_long, too_long_next, base_too_long;
    logic [7:0]             lut_ascii, letter;
    logic                   gap_close, push_en;
    logic [7:0]             push_data;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          pop, full, push_ok;

    morse_lut u_lut (
        .len     (len),
        .pattern (pattern),
        .ascii   (lut_ascii)
    );

    assign letter = too_long ? ASCII_UNKNOWN : lut_ascii;

    always_comb begin
        state_next = state;
        gap_close  = 1'b0;
        push_en    = 1'b0;
        push_data  = letter;

        case (state)
            COLLECT: begin
                if ((lg || wg) && len != '0) begin
                    gap_close = 1'b1;
                    push_en   = 1'b1;
                    if (wg) state_next = EMIT_SPACE;
                end
            end
            EMIT_SPACE: begin
                push_en    = 1'b1;
                push_data  = ASCII_SPACE;
                state_next = COLLECT;
            end
        endcase

        // A gap on this edge closes the old symbol first, so an element
        // arriving together with it starts a fresh symbol.
        base_len      = gap_close ? '0   : len;
        base_pat      = gap_close ? '0   : pattern;
        base_too_long = gap_close ? 1'b0 : too_long;

        len_next      = base_len;
        pattern_next  = base_pat;
        too_long_next = base_too_long;
        if (dot || dash) begin
            if (base_len == LEN_MAX) begin
                too_long_next = 1'b1;
            end else begin
                len_next     = base_len + 1'b1;
                pattern_next = {base_pat[MORSE_PAT_W-2:0], dash};
            end
            // Both pulses at once is illegal: recorded as a dash, decodes to '?'.
            if (dot && dash) too_long_next = 1'b1;
        end
    end

    assign pop        = char_valid & char_ready;
    assign full       = (count == FULL_COUNT);
    assign push_ok    = push_en & (~full | pop);
    assign char_valid = (count != '0);
    assign char_data  = char_valid ? mem[rd_ptr] : 8'h00;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= COLLECT;
            len      <= '0;
            pattern  <= '0;
            too_long <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            len      <= len_next;
            pattern  <= pattern_next;
            too_long <= too_long_next;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push_en && full && !pop) overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible
    // because char_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_morse_char_assembler.sv
// -----------------------------------------------------------------------------
// tb_morse_char_assembler
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model that
// keeps the symbol as a dot/dash string and the FIFO as a queue.
// -----------------------------------------------------------------------------
module tb_morse_char_assembler;

    logic       clk;
    logic       reset;
    logic       dot, dash, lg, wg;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       overflow;

    morse_char_assembler #(.FIFO_DEPTH(4), .MAX_ELEMENTS(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .dot        (dot),
        .dash       (dash),
        .lg         (lg),
        .wg         (wg),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_DEPTH = 4;
    localparam int M_MAXEL = 5;

    byte unsigned lut [string];
    byte unsigned mq [$];
    string        msym;
    bit           mtl, mspace, movf;

    string codes [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    function automatic byte unsigned mletter(input string s, input bit tl);
        if (tl || !lut.exists(s)) return 8'h3F;
        return lut[s];
    endfunction

    task automatic model_reset();
        mq.delete();
        msym   = "";
        mtl    = 1'b0;
        mspace = 1'b0;
        movf   = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit s, input bit l, input bit w, input bit r);
        bit          pop;
        bit          push;
        byte unsigned pv;
        pop  = r && (mq.size() > 0);
        push = 1'b0;
        pv   = 8'h00;
        if (mspace) begin
            push   = 1'b1;
            pv     = 8'h20;
            mspace = 1'b0;
        end else if ((l || w) && msym.len() > 0) begin
            push = 1'b1;
            pv   = mletter(msym, mtl);
            msym = "";
            mtl  = 1'b0;
            if (w) mspace = 1'b1;
        end
        if (d || s) begin
            if (msym.len() >= M_MAXEL) mtl = 1'b1;
            else if (s)                msym = {msym, "-"};
            else                       msym = {msym, "."};
            if (d && s) mtl = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < M_DEPTH) mq.push_back(pv);
            else                     movf = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 36; i++)
            lut[codes[i]] = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset) model_step(dot, dash, lg, wg, char_ready);
        end
    end

    // Single compare process: DUT outputs against the model every cycle.
    initial begin
        wait (check_en);
        forever begin
            @(negedge clk);
            check("cmp_valid", char_valid, (mq.size() != 0));
            if (mq.size() != 0) check("cmp_data", char_data, mq[0]);
            check("cmp_overflow", overflow, movf);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; holds the inputs across one edge, then clears them.
    task automatic cyc(input bit d, input bit s, input bit l, input bit w);
        dot = d; dash = s; lg = l; wg = w;
        @(posedge clk);
        #1;
        dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_valid", char_valid, 1'b0);
        check("rst_data", char_data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0;
        char_ready = 1'b1;
        #3;
        check("reset_valid", char_valid, 1'b0);
        check("reset_data", char_data, 8'h00);
        check("reset_overflow", overflow, 1'b0);
        #9 reset = 1'b0;
        @(posedge clk);
        #1;
        check_en = 1'b1;

        // 1: .- closed by lg gives 'A', visible for exactly one cycle
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
        check("t1_valid", char_valid, 1'b1);
        check("t1_data", char_data, 8'h41);
        idle(1);
        check("t1_drop", char_valid, 1'b0);

        // 2: -... closed by wg gives 'B' then a space; a bare wg adds nothing
        cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("t2_letter", char_data, 8'h42);
        idle(1);
        check("t2_space", char_data, 8'h20);
        idle(1);
        check("t2_empty", char_valid, 1'b0);
        cyc(0, 0, 0, 1);
        idle(1);
        check("t2_no_dup_space", char_valid, 1'b0);

        // 3: ...-- is '3'; six dots is too long; ..-- is unassigned
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        check("t3_three", char_data, 8'h33);
        idle(1);
        repeat (6) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        check("t3_too_long", char_data, 8'h3F);
        idle(1);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        check("t3_unassigned", char_data, 8'h3F);
        idle(1);

        // 4: five E's into a stalled 4-deep FIFO, then drain
        char_ready = 1'b0;
        repeat (5) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 1, 0);
        end
        check("t4_overflow", overflow, 1'b1);
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_drain_valid", char_valid, 1'b1);
            check("t4_drain_data", char_data, 8'h45);
            idle(1);
        end
        check("t4_empty", char_valid, 1'b0);

        // 6a: queued char and partial symbol wiped by an async mid-cycle reset
        char_ready = 1'b0;
        cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        async_reset_pulse();
        char_ready = 1'b1;
        cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
        check("t6_e_only", char_data, 8'h45);
        idle(1);
        check("t6_single", char_valid, 1'b0);

        // 6b: dot together with lg after "-" yields 'T', dot starts next symbol
        cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 0);
        check("t6_t", char_data, 8'h54);
        cyc(0, 0, 1, 0);
        check("t6_next_e", char_data, 8'h45);
        idle(1);
        check("t6_empty", char_valid, 1'b0);

        // 5: push onto a full FIFO on the same edge as a pop is accepted
        char_ready = 1'b0;
        repeat (4) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 1, 0);
        end
        cyc(0, 1, 0, 0);
        char_ready = 1'b1;
        cyc(0, 0, 1, 0);
        check("t5_no_overflow", overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t5_order", char_data, (i == 3) ? 8'h54 : 8'h45);
            idle(1);
        end
        check("t5_empty", char_valid, 1'b0);

        // Randomized run against the model, with stall phases and resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) async_reset_pulse();
            if ((i / 250) % 2 == 1) char_ready = ($urandom_range(0, 3) == 0);
            else                    char_ready = ($urandom_range(0, 3) != 0);
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
